// File: rtl/div_unit_if.sv
// ---------------------------------------------------------------------------
// div_unit_pkg / div_unit_if
//
// Purpose:
//   Shared types for the divide functional unit, plus the interface that
//   bundles its issue-side and writeback-side handshakes.
//
// Interface signals (directions as seen by the divide unit, modport slave):
//   in_valid_i    in   issue offers an op
//   in_ready_o    out  unit can accept an op
//   in_i          in   fu_input_t operation bundle
//   out_valid_o   out  result available
//   out_ready_i   in   writeback accepts result
//   out_id_o      out  tag of the result
//   out_prd_o     out  destination physical register
//   out_pc_o      out  pc of the producing op
//   out_result_o  out  quotient or remainder
// ---------------------------------------------------------------------------
package div_unit_pkg;
  localparam int C_XLEN         = 64;
  localparam int C_ID_BITS      = 20;
  localparam int C_PREG_ID_BITS = 4;

  typedef enum logic [2:0] {
    FU_ALU, FU_BRANCH, FU_LSU, FU_MUL, FU_DIV
  } fu_t;

  typedef enum logic [2:0] {
    DIV, DIVU, DIVW, DIVUW, REM, REMU, REMW, REMUW
  } div_op_t;

  typedef struct packed {
    div_op_t div;
  } fu_op_t;

  typedef struct packed {
    logic [C_XLEN-1:0]         pc;
    logic [C_ID_BITS-1:0]      id;
    logic [C_PREG_ID_BITS-1:0] prd;
    logic [C_XLEN-1:0]         rs1val;
    logic [C_XLEN-1:0]         rs2val;
    logic [C_XLEN-1:0]         imm;
    fu_t                       fu;
    fu_op_t                    op;
  } fu_input_t;
endpackage

interface div_unit_if;
  logic                                   in_valid_i;
  logic                                   in_ready_o;
  div_unit_pkg::fu_input_t                in_i;
  logic                                   out_valid_o;
  logic                                   out_ready_i;
  logic [div_unit_pkg::C_ID_BITS-1:0]      out_id_o;
  logic [div_unit_pkg::C_PREG_ID_BITS-1:0] out_prd_o;
  logic [div_unit_pkg::C_XLEN-1:0]         out_pc_o;
  logic [div_unit_pkg::C_XLEN-1:0]         out_result_o;

  // Issue / writeback side
  modport master (
    output in_valid_i, in_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_id_o, out_prd_o, out_pc_o, out_result_o
  );

  // Divide unit side
  modport slave (
    input  in_valid_i, in_i, out_ready_i,
    output in_ready_o, out_valid_o, out_id_o, out_prd_o, out_pc_o, out_result_o
  );
endinterface

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//
// Purpose:
//   Iterative integer divide/remainder unit (DIV, DIVU, DIVW, DIVUW, REM,
//   REMU, REMW, REMUW). Radix-2 restoring division, one quotient bit per
//   cycle, MSB first; one operation in flight. Divide-by-zero and signed
//   overflow resolve in a single cycle.
//
// Ports:
//   clk_i    in   clock
//   rst_ni   in   synchronous active-low reset
//   flush_i  in   kill in-flight op and pending result
//   bus      --   div_unit_if.slave (issue and writeback handshakes)
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int XLEN         = div_unit_pkg::C_XLEN,
  parameter int ID_BITS      = div_unit_pkg::C_ID_BITS,
  parameter int PREG_ID_BITS = div_unit_pkg::C_PREG_ID_BITS
) (
  input logic       clk_i,
  input logic       rst_ni,
  input logic       flush_i,
  div_unit_if.slave bus
);
  import div_unit_pkg::*;

  localparam int WLEN  = 32;
  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t r_state, w_state_next;

  // Operation registers
  logic [ID_BITS-1:0]      r_id;
  logic [PREG_ID_BITS-1:0] r_prd;
  logic [XLEN-1:0]         r_pc;
  logic [XLEN-1:0]         r_result;
  logic                    r_is_w, r_is_rem, r_q_neg, r_r_neg;
  logic [CNT_W-1:0]        r_cnt;
  logic [XLEN-1:0]         r_rem, r_quo, r_div;

  // Decode
  div_op_t         w_op;
  logic            w_is_w, w_is_signed, w_is_rem;
  logic [XLEN-1:0] w_rs1, w_rs2;
  assign w_op  = bus.in_i.op.div;
  assign w_rs1 = bus.in_i.rs1val;
  assign w_rs2 = bus.in_i.rs2val;
  assign w_is_w      = (w_op == DIVW) || (w_op == DIVUW) || (w_op == REMW) || (w_op == REMUW);
  assign w_is_signed = (w_op == DIV) || (w_op == DIVW) || (w_op == REM) || (w_op == REMW);
  assign w_is_rem    = (w_op == REM) || (w_op == REMU) || (w_op == REMW) || (w_op == REMUW);

  // Operand magnitudes and signs
  logic            w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  always_comb begin
    w_a_neg = w_is_signed & (w_is_w ? w_rs1[WLEN-1] : w_rs1[XLEN-1]);
    w_b_neg = w_is_signed & (w_is_w ? w_rs2[WLEN-1] : w_rs2[XLEN-1]);
    if (w_is_w) begin
      w_a_mag = {{(XLEN-WLEN){1'b0}}, (w_a_neg ? (32'd0 - w_rs1[WLEN-1:0]) : w_rs1[WLEN-1:0])};
      w_b_mag = {{(XLEN-WLEN){1'b0}}, (w_b_neg ? (32'd0 - w_rs2[WLEN-1:0]) : w_rs2[WLEN-1:0])};
    end else begin
      w_a_mag = w_a_neg ? ('0 - w_rs1) : w_rs1;
      w_b_mag = w_b_neg ? ('0 - w_rs2) : w_rs2;
    end
  end

  // Special cases: both return values derive from the op-width dividend
  logic            w_b_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_dividend, w_special_res;
  always_comb begin
    w_b_zero   = w_is_w ? (w_rs2[WLEN-1:0] == '0) : (w_rs2 == '0);
    w_ovf      = w_is_signed & (w_is_w ?
                 ((w_rs1[WLEN-1:0] == 32'h8000_0000) && (&w_rs2[WLEN-1:0])) :
                 ((w_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&w_rs2)));
    w_special  = w_b_zero | w_ovf;
    w_dividend = w_is_w ? {{(XLEN-WLEN){w_rs1[WLEN-1]}}, w_rs1[WLEN-1:0]} : w_rs1;
    if (w_b_zero) w_special_res = w_is_rem ? w_dividend : '1;
    else          w_special_res = w_is_rem ? '0 : w_dividend;
  end

  // One restoring step. The partial remainder stays below the divisor, so
  // the doubled value fits XLEN+1 bits and the top bit of the difference is
  // a clean borrow flag.
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_bit;
  logic [XLEN-1:0] w_rem_step, w_quo_step;
  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_div};
  assign w_bit      = ~w_diff[XLEN];
  assign w_rem_step = w_bit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_step = {r_quo[XLEN-2:0], w_bit};

  // Final select, sign fixup and W sign-extension on the last step
  logic [XLEN-1:0] w_raw, w_fix, w_final;
  logic            w_neg;
  always_comb begin
    w_raw   = r_is_rem ? w_rem_step : w_quo_step;
    w_neg   = r_is_rem ? r_r_neg : r_q_neg;
    w_fix   = w_neg ? ('0 - w_raw) : w_raw;
    w_final = r_is_w ? {{(XLEN-WLEN){w_fix[WLEN-1]}}, w_fix[WLEN-1:0]} : w_fix;
  end

  // FSM
  logic w_in_ready, w_accept, w_finish;
  assign w_in_ready = (r_state == S_IDLE) & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    unique case (r_state)
      S_IDLE: if (bus.in_valid_i && w_in_ready) begin
        w_accept     = 1'b1;
        w_state_next = w_special ? S_DONE : S_BUSY;
      end
      S_BUSY: if (r_cnt == '0) begin
        w_finish     = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: if (bus.out_ready_i) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    // Flush wins over every transition, including the output handshake
    if (flush_i) begin
      w_state_next = S_IDLE;
      w_finish     = 1'b0;
    end
  end

  // Datapath
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_id     <= '0;
      r_prd    <= '0;
      r_pc     <= '0;
      r_result <= '0;
      r_is_w   <= 1'b0;
      r_is_rem <= 1'b0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
    end else if (w_accept) begin
      r_id     <= bus.in_i.id;
      r_prd    <= bus.in_i.prd;
      r_pc     <= bus.in_i.pc;
      r_is_w   <= w_is_w;
      r_is_rem <= w_is_rem;
      r_q_neg  <= w_a_neg ^ w_b_neg;
      r_r_neg  <= w_a_neg;
      // Counter holds remaining steps minus one; DONE follows the step at 0
      r_cnt    <= w_is_w ? CNT_W'(WLEN - 1) : CNT_W'(XLEN - 1);
      r_rem    <= '0;
      // W dividends are left-aligned so the MSB-first shift starts at bit 31
      r_quo    <= w_is_w ? {w_a_mag[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : w_a_mag;
      r_div    <= w_b_mag;
      if (w_special) r_result <= w_special_res;
    end else if (r_state == S_BUSY) begin
      r_rem <= w_rem_step;
      r_quo <= w_quo_step;
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_finish) r_result <= w_final;
    end
  end

  assign bus.in_ready_o   = w_in_ready;
  assign bus.out_valid_o  = (r_state == S_DONE);
  assign bus.out_id_o     = r_id;
  assign bus.out_prd_o    = r_prd;
  assign bus.out_pc_o     = r_pc;
  assign bus.out_result_o = r_result;

  // The immediate field plays no part in division
  logic w_unused_imm;
  assign w_unused_imm = ^bus.in_i.imm;

  // Only divide ops may be handed to this unit
  always @(posedge clk_i) begin
    if (rst_ni && w_accept) begin
      a_fu_is_div: assert (bus.in_i.fu == FU_DIV)
        else $error("div_unit: accepted op with fu != FU_DIV");
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
//
// Self-checking bench for div_unit: directed literal cases, back-pressure,
// flush and mid-op reset, then randomized traffic with random output
// back-pressure. A cycle-level reference (pending flag + due cycle + result
// from plain arithmetic) is compared against the DUT on every cycle.
// ---------------------------------------------------------------------------
module tb_div_unit;
  import div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  div_unit_if u_if();

  div_unit u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (u_if)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_result(div_op_t op, logic [63:0] a, logic [63:0] b);
    logic        w, s, r;
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    w = op inside {DIVW, DIVUW, REMW, REMUW};
    s = op inside {DIV, DIVW, REM, REMW};
    r = op inside {REM, REMU, REMW, REMUW};
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0)                                           r32 = r ? a32 : 32'hFFFF_FFFF;
      else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = r ? 32'd0 : a32;
      else if (s) begin
        if (r) r32 = $signed(a32) % $signed(b32);
        else   r32 = $signed(a32) / $signed(b32);
      end else begin
        if (r) r32 = a32 % b32;
        else   r32 = a32 / b32;
      end
      return {{32{r32[31]}}, r32};
    end
    if (b == 64'd0)                                                   r64 = r ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r64 = r ? 64'd0 : a;
    else if (s) begin
      if (r) r64 = $signed(a) % $signed(b);
      else   r64 = $signed(a) / $signed(b);
    end else begin
      if (r) r64 = a % b;
      else   r64 = a / b;
    end
    return r64;
  endfunction

  function automatic int model_latency(div_op_t op, logic [63:0] a, logic [63:0] b);
    logic w, s;
    w = op inside {DIVW, DIVUW, REMW, REMUW};
    s = op inside {DIV, DIVW, REM, REMW};
    if (w) begin
      if (b[31:0] == 32'd0) return 1;
      if (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    if (b == 64'd0) return 1;
    if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
    return 65;
  endfunction

  // ---------------- per-cycle compare process ----------------
  bit          mon_en = 1'b0;
  int          cyc = 0;
  bit          m_pending = 1'b0;
  int          m_due = 0;
  logic [63:0] m_res, m_pc;
  logic [19:0] m_id;
  logic [3:0]  m_prd;

  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_rdy;
      bit exp_val;
      exp_rdy = !m_pending && !flush;
      exp_val = m_pending && (cyc >= m_due);
      check("in_ready", u_if.in_ready_o, exp_rdy);
      check("out_valid", u_if.out_valid_o, exp_val);
      if (exp_val) begin
        check("out_id", u_if.out_id_o, m_id);
        check("out_prd", u_if.out_prd_o, m_prd);
        check("out_pc", u_if.out_pc_o, m_pc);
        check("out_result", u_if.out_result_o, m_res);
      end
      if (!rst_n || flush) begin
        m_pending = 1'b0;
      end else if (exp_val && u_if.out_ready_i) begin
        $display("[TB] cycle %0d result id=%0d prd=%0d result=%h", cyc, m_id, m_prd, m_res);
        m_pending = 1'b0;
      end else if (exp_rdy && u_if.in_valid_i) begin
        m_pending = 1'b1;
        m_due = cyc + model_latency(u_if.in_i.op.div, u_if.in_i.rs1val, u_if.in_i.rs2val);
        m_res = model_result(u_if.in_i.op.div, u_if.in_i.rs1val, u_if.in_i.rs2val);
        m_id  = u_if.in_i.id;
        m_prd = u_if.in_i.prd;
        m_pc  = u_if.in_i.pc;
      end
      cyc++;
    end
  end

  // ---------------- random output back-pressure ----------------
  bit ready_random = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_random) u_if.out_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver helpers ----------------
  logic [19:0] next_id = 20'd1;

  task automatic issue(div_op_t op, logic [63:0] a, logic [63:0] b);
    bit done;
    done = 1'b0;
    u_if.in_i.op.div = op;
    u_if.in_i.rs1val = a;
    u_if.in_i.rs2val = b;
    u_if.in_i.imm    = {$urandom, $urandom};
    u_if.in_i.pc     = {$urandom, $urandom};
    u_if.in_i.id     = next_id;
    u_if.in_i.prd    = 4'($urandom_range(0, 15));
    u_if.in_i.fu     = FU_DIV;
    next_id++;
    u_if.in_valid_i = 1'b1;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (u_if.in_ready_o) done = 1'b1;
      @(posedge clk);
      #1;
    end
    u_if.in_valid_i = 1'b0;
    if (!done) check("issue timeout", 64'd0, 64'd1);
  endtask

  // Issue, then measure cycles from handshake to out_valid and check the
  // result against a hand-computed value.
  task automatic run_directed(string name, div_op_t op, logic [63:0] a, logic [63:0] b,
                              logic [63:0] exp, int lat);
    int n;
    bit seen;
    issue(op, a, b);
    n = 1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (u_if.out_valid_o) begin
        seen = 1'b1;
        check({name, " result"}, u_if.out_result_o, exp);
        check({name, " latency"}, 64'(n), 64'(lat));
      end else begin
        n++;
      end
    end
    if (!seen) check({name, " timeout"}, 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return {$urandom, 32'h8000_0000};
      4:       return 64'($urandom_range(1, 20));
      5:       return {32'hFFFF_FFFF, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] held;
    bit          seen;
    int          cnt;

    u_if.in_valid_i  = 1'b0;
    u_if.in_i        = '0;
    u_if.in_i.fu     = FU_DIV;
    u_if.out_ready_i = 1'b1;

    // Pin the model on a few hand-computed values
    check("model DIVU 100/7", model_result(DIVU, 64'd100, 64'd7), 64'd14);
    check("model REM -20/3", model_result(REM, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3), 64'hFFFF_FFFF_FFFF_FFFE);
    check("model DIVW ovf", model_result(DIVW, 64'h1_8000_0000, 64'hFFFF_FFFF), 64'hFFFF_FFFF_8000_0000);
    check("model DIVUW lat", 64'(model_latency(DIVUW, 64'h1_0000_0006, 64'd3)), 64'd33);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", u_if.in_ready_o, 1);
    check("reset out_valid", u_if.out_valid_o, 0);
    check("reset out_id", u_if.out_id_o, 0);
    check("reset out_prd", u_if.out_prd_o, 0);
    check("reset out_pc", u_if.out_pc_o, 0);
    check("reset out_result", u_if.out_result_o, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Directed cases with literal expectations
    run_directed("DIVU 100/7", DIVU, 64'd100, 64'd7, 64'd14, 65);
    run_directed("REMU 100/7", REMU, 64'd100, 64'd7, 64'd2, 65);
    run_directed("DIV -20/3", DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
    run_directed("REM -20/3", REM, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_directed("DIVW ovf", DIVW, 64'h1_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_directed("REMUW 7/0", REMUW, 64'd7, 64'd0, 64'd7, 1);
    run_directed("DIV 5/0", DIV, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_directed("REM 5/0", REM, 64'd5, 64'd0, 64'd5, 1);
    run_directed("DIVUW 6/3", DIVUW, 64'h1_0000_0006, 64'd3, 64'd2, 33);
    run_directed("DIV ovf64", DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 1);
    run_directed("REMW -7/2", REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);

    // Back-pressure: hold the result for 10 cycles
    u_if.out_ready_i = 1'b0;
    issue(DIVU, 64'd1000, 64'd10);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (u_if.out_valid_o) seen = 1'b1;
    end
    if (!seen) check("bp timeout", 64'd0, 64'd1);
    held = u_if.out_result_o;
    check("bp first result", held, 64'd100);
    repeat (10) @(negedge clk);
    check("bp held result", u_if.out_result_o, 64'd100);
    check("bp held valid", u_if.out_valid_o, 1);
    check("bp in_ready low", u_if.in_ready_o, 0);
    @(posedge clk);
    #1;
    u_if.out_ready_i = 1'b1;
    @(negedge clk);
    check("bp handshake valid", u_if.out_valid_o, 1);
    @(negedge clk);
    check("bp in_ready after", u_if.in_ready_o, 1);
    @(posedge clk);
    #1;

    // Flush at BUSY cycle 20 with an offered op
    issue(DIVU, {$urandom, $urandom}, 64'd3);
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    u_if.in_valid_i = 1'b1;
    u_if.in_i.op.div = DIVU;
    u_if.in_i.id = next_id;
    @(negedge clk);
    check("flush in_ready", u_if.in_ready_o, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    u_if.in_valid_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (u_if.out_valid_o) cnt++;
    end
    check("flush no result", 64'(cnt), 64'd0);
    @(posedge clk);
    #1;
    run_directed("DIVU 9/3", DIVU, 64'd9, 64'd3, 64'd3, 65);

    // Randomized traffic with random back-pressure
    ready_random = 1'b1;
    for (int k = 0; k < 60; k++) begin
      issue(div_op_t'($urandom_range(0, 7)), rand_operand(), rand_operand());
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 5)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    for (int i = 0; i < 500 && m_pending; i++) begin
      @(posedge clk);
      #1;
    end
    if (m_pending) check("drain timeout", 64'd0, 64'd1);
    ready_random = 1'b0;
    u_if.out_ready_i = 1'b1;
    @(posedge clk);
    #1;

    // Reset mid-operation clears the output registers
    issue(DIVU, 64'd77, 64'd7);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset out_valid", u_if.out_valid_o, 0);
    check("midreset out_result", u_if.out_result_o, 0);
    check("midreset out_id", u_if.out_id_o, 0);
    check("midreset in_ready", u_if.in_ready_o, 1);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    run_directed("DIVU 9/3 after reset", DIVU, 64'd9, 64'd3, 64'd3, 65);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit reached, expected completion before it");
    $fatal(1, "tb_div_unit: time limit reached");
  end
endmodule
